// File: rtl/ha_array_pkg.sv
// Shared definitions for the half-adder array reducer.
//   HA_GROUPS : number of half-adder groups from the partial-product stage
//   HA_B_W    : carry bits per group
//   HA_T_W    : sum bits per group
//   HA_GV_W   : width of one group value t + (b << 2)
//   HA_PS_W   : width of a stage-1 partial sum
//   HA_SUM_W  : width of the full internal sum
//   ha_group_t: one group's carry (b) and sum (t) bits
package ha_array_pkg;

    localparam int unsigned HA_GROUPS = 4;
    localparam int unsigned HA_B_W    = 7;
    localparam int unsigned HA_T_W    = 9;
    localparam int unsigned HA_GV_W   = 10;
    // G_0 + (G_1 << 2) reaches 5 * 1019 = 5095, which needs 13 bits to keep every input bit.
    localparam int unsigned HA_PS_W   = 13;
    localparam int unsigned HA_SUM_W  = 17;

    typedef struct packed {
        logic [HA_B_W-1:0] b;
        logic [HA_T_W-1:0] t;
    } ha_group_t;

endpackage

// File: rtl/ha_array_reducer_if.sv
// Handshake and data bundle for ha_array_reducer.
//   in_valid/in_ready     : upstream handshake
//   ha_array_g_b/_t       : carry/sum bits of group g (g = 0..3)
//   out_valid/out_ready   : downstream handshake
//   product, ovf          : reduced product and bit 16 of the internal sum
// Modports: master = producer/consumer side, slave = reducer side.
interface ha_array_reducer_if #(
    parameter int unsigned OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       ha_array_0_b;
    logic [8:0]       ha_array_0_t;
    logic [6:0]       ha_array_1_b;
    logic [8:0]       ha_array_1_t;
    logic [6:0]       ha_array_2_b;
    logic [8:0]       ha_array_2_t;
    logic [6:0]       ha_array_3_b;
    logic [8:0]       ha_array_3_t;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] product;
    logic             ovf;

    modport master (
        output in_valid, ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
               ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t, out_ready,
        input  in_ready, out_valid, product, ovf
    );

    modport slave (
        input  in_valid, ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
               ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t, out_ready,
        output in_ready, out_valid, product, ovf
    );
endinterface

// File: rtl/ha_group_value.sv
// Combinational value of one half-adder group: G = t + (b << 2).
//   grp   : in  carry (b) and sum (t) bits of the group
//   value : out 10-bit group value, max 1019
module ha_group_value
    import ha_array_pkg::*;
(
    input  ha_group_t            grp,
    output logic [HA_GV_W-1:0]   value
);
    assign value = HA_GV_W'(grp.t) + (HA_GV_W'(grp.b) << 2);
endmodule

// File: rtl/ha_array_reducer.sv
// Two-stage pipelined final adder for the approximate 8x8 multiplier's HA arrays.
// Stage 1 registers L = G0 + (G1 << 2) and H = G2 + (G3 << 2); stage 2 registers
// S = L + (H << 4) as product/ovf. Valid/ready on both sides, full throughput.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ha_array_reducer_if.slave (handshakes, group arrays, product, ovf)
// Build option: HA_REDUCER_SAT_EN saturates product to all ones when S[16] is set.
module ha_array_reducer
    import ha_array_pkg::*;
#(
    parameter int unsigned OUT_W = 16
) (
    input logic              clk,
    input logic              rst,
    ha_array_reducer_if.slave bus
);
    ha_group_t              grp [HA_GROUPS];
    logic [HA_GV_W-1:0]     gv  [HA_GROUPS];

    assign grp[0] = '{b: bus.ha_array_0_b, t: bus.ha_array_0_t};
    assign grp[1] = '{b: bus.ha_array_1_b, t: bus.ha_array_1_t};
    assign grp[2] = '{b: bus.ha_array_2_b, t: bus.ha_array_2_t};
    assign grp[3] = '{b: bus.ha_array_3_b, t: bus.ha_array_3_t};

    for (genvar g = 0; g < HA_GROUPS; g++) begin : gen_grp
        ha_group_value u_gv (
            .grp   (grp[g]),
            .value (gv[g])
        );
    end

    logic                s1_valid_q;
    logic [HA_PS_W-1:0]  l_q, h_q, l_d, h_d;
    logic                out_valid_q;
    logic [OUT_W-1:0]    product_q, product_d;
    logic                ovf_q;
    logic [HA_SUM_W-1:0] sum_d;
    logic                s2_advance;
    logic                in_ready;

    assign s2_advance = !out_valid_q || bus.out_ready;
    // Reported ready during reset so upstream never stalls on it; the reset branch drops the data.
    assign in_ready   = rst || !s1_valid_q || s2_advance;

    always_comb begin
        l_d   = HA_PS_W'(gv[0]) + (HA_PS_W'(gv[1]) << 2);
        h_d   = HA_PS_W'(gv[2]) + (HA_PS_W'(gv[3]) << 2);
        sum_d = HA_SUM_W'(l_q) + (HA_SUM_W'(h_q) << 4);
`ifdef HA_REDUCER_SAT_EN
        product_d = sum_d[HA_SUM_W-1] ? '1 : sum_d[OUT_W-1:0];
`else
        product_d = sum_d[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            l_q         <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (s2_advance) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    product_q <= product_d;
                    ovf_q     <= sum_d[HA_SUM_W-1];
                end
            end
            if (in_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    l_q <= l_d;
                    h_q <= h_d;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.ovf       = ovf_q;
endmodule
